lcd_bus_master: RTL and testbench
=================================

# lcd_bus_master

Hardware-side initiator for the 16-bit 8080-style LCD bus on the LCD2 port. It produces the `lcd2_*_hw` signal set that the CPU/hardware bus switch routes to the panel when hardware mode is selected. It runs the panel reset sequence after system reset, then accepts command and data words on a valid/ready stream and converts each into a timed CS/WR/RS bus cycle. Optionally, it also performs RD read cycles.

## Interface
Parameters:
- `WR_LOW_CYC`, default 2: clocks WR is held low per write; must be ≥1.
- `WR_HIGH_CYC`, default 2: clocks WR is held high per write; must be ≥1.
- `RD_LOW_CYC`, default 4: clocks RD is held low per read; must be ≥1.
- `RD_HIGH_CYC`, default 4: clocks RD is held high per read; must be ≥1.
- `RST_LOW_CYC`, default 1000: clocks `lcd2_reset_hw` is held low after `rst`.
- `RST_WAIT_CYC`, default 5000: clocks waited after panel reset release before the first accept.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: a transfer request is presented.
- `cmd_ready` output 1: the block accepts the request this cycle.
- `cmd_rs` input 1: 0 = command/index, 1 = data/parameter.
- `cmd_rd` input 1: 1 = read cycle. Used only with `LCD_READ_EN`.
- `cmd_data` input 16: write word.
- `rd_valid` output 1: one-cycle pulse marking read data valid.
- `rd_data` output 16: captured read word.
- `init_done` output 1: panel reset sequence complete.
- `lcd2_cs_hw`, `lcd2_wr_hw`, `lcd2_rs_hw`, `lcd2_reset_hw`, `lcd2_rd_hw` output 1 each: bus strobes. All are active-low except RS.
- `lcd2_data16_hw` output 16: driven bus word.
- `lcd2_data16_oe` output 1: 1 = drive the bus, 0 = release it for a read.
- `lcd2_data16_in` input 16: bus value sampled during reads.

## Operation
- All outputs are registered.
- Reset values:
  - `lcd2_cs_hw=1`, `lcd2_wr_hw=1`, `lcd2_rd_hw=1`, `lcd2_rs_hw=0`, `lcd2_reset_hw=0`.
  - `lcd2_data16_hw=0`, `lcd2_data16_oe=1`.
  - `cmd_ready=0`, `rd_valid=0`, `rd_data=0`, `init_done=0`.
- States: RST_LOW, RST_WAIT, IDLE, WR_LO, WR_HI, RD_LO, RD_HI. A single down-counter, 24 bits wide, times every state.
- RST_LOW: `lcd2_reset_hw=0` for `RST_LOW_CYC` clocks, then go to RST_WAIT.
- RST_WAIT: `lcd2_reset_hw=1` for `RST_WAIT_CYC` clocks. Then go to IDLE and set `init_done=1`, which holds until the next `rst`.
- IDLE: `cs=1`, `cmd_ready=1`.
- Accept: `cmd_valid && cmd_ready`. `cmd_rs` and `cmd_data` are latched; go to WR_LO, or to RD_LO when `cmd_rd=1` and reads are enabled.
- WR_LO / WR_HI:
  - `cs=0`, `rs` = latched value, data = latched word, `oe=1`.
  - WR is low for `WR_LOW_CYC` clocks, then high for `WR_HIGH_CYC` clocks.
  - RS and data remain stable through WR_HI, so the panel latches on the WR rising edge with hold time.
- RD_LO / RD_HI:
  - `cs=0`, `oe=0`, RD is low for `RD_LOW_CYC` clocks, then high for `RD_HIGH_CYC` clocks.
  - `lcd2_data16_in` is sampled on the last clock of RD_LO into `rd_data`.
  - `rd_valid=1` on the first clock of RD_HI.
  - `oe` returns to 1 when leaving RD_HI.
- Back-to-back transfers:
  - `cmd_ready` is also 1 on the last clock of WR_HI or RD_HI.
  - If a new accept happens on that clock, the next phase starts on the next clock with CS held low, with no idle gap.
  - Otherwise the block goes to IDLE and CS rises.
- Requests arriving before `init_done` are not accepted. `cmd_ready` stays 0 and the requester holds `cmd_valid`.
- `rst` mid-operation: on the next edge, every output takes its reset value and the state becomes RST_LOW. The in-flight transfer is dropped, not completed, and the full panel reset sequence reruns.

## Timing
- Accept at edge T: the bus phase starts at T+1.
- Write cost is `WR_LOW_CYC+WR_HIGH_CYC` clocks; back-to-back throughput is one word per that many clocks.
- Read data latency: `rd_valid` asserts `RD_LOW_CYC` clocks after the accept edge.
- Time from `rst` deassert to the first `cmd_ready` is `RST_LOW_CYC+RST_WAIT_CYC` clocks.
- CS rises one clock after the final WR_HI or RD_HI clock when no request follows.

## Configuration
- `LCD_READ_EN` defined: RD_LO/RD_HI exist and `cmd_rd` selects a read cycle.
- `LCD_READ_EN` undefined:
  - `cmd_rd` is ignored and every accept is a write.
  - `lcd2_rd_hw` is tied 1, `lcd2_data16_oe` is tied 1, `rd_valid` is tied 0, `rd_data` is tied 0.
  - The read states and the capture register are not built.

## Test plan
- Power-up with `RST_LOW_CYC=8`, `RST_WAIT_CYC=16`, `rst` high 2 clocks -> `lcd2_reset_hw` is 0 for 8 clocks after release, then 1. `cmd_ready` and `init_done` rise 16 clocks later.
- Single write, `rs=0`, `data=0x002C` -> CS low for 4 clocks, WR low 2 then high 2, bus 0x002C with `rs=0` throughout, CS high on the next clock.
- Four data words 0xF800, 0x07E0, 0x001F, 0xFFFF with `cmd_valid` held -> CS continuously low for 16 clocks, 4 WR pulses with a period of 4, each word stable across its WR rising edge.
- `LCD_READ_EN` defined, `cmd_rd=1`, `lcd2_data16_in=0x9341` -> `oe=0`, RD low 4 clocks, `rd_valid` for exactly one clock with `rd_data=0x9341`, `oe=1` after RD_HI.
- `rst` pulsed during WR_LO -> next clock has `cs=1`, `wr=1`, `lcd2_reset_hw=0`, `cmd_ready=0`, `init_done=0`, and the full reset sequence repeats.
- `LCD_READ_EN` undefined, `cmd_rd=1`, `data=0x1234` -> a normal write of 0x1234, with `lcd2_rd_hw` constant 1 and `rd_valid` constant 0.

Source files
------------

// File: rtl/lcd_bus_master.sv
// lcd_bus_master: hardware-side initiator for the 16-bit 8080-style LCD2 bus.
// It runs the panel reset sequence after rst. It then turns each accepted
// command/data word into a timed CS/WR/RS write cycle.
// Optional feature macro: LCD_READ_EN adds RD read cycles with data capture.
// When LCD_READ_EN is undefined, cmd_rd is ignored and the read outputs are
// tied to their idle values.
// Handshake: a request transfers on any clock edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high in IDLE and on the final clock
// of a bus cycle, which allows back-to-back transfers. The requester must hold
// cmd_valid and its payload until the transfer.
// FSM state is held in the 'state' signal so checkers can bind to it.
module lcd_bus_master #(
    parameter int WR_LOW_CYC   = 2,
    parameter int WR_HIGH_CYC  = 2,
    parameter int RD_LOW_CYC   = 4,
    parameter int RD_HIGH_CYC  = 4,
    parameter int RST_LOW_CYC  = 1000,
    parameter int RST_WAIT_CYC = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rs,
    input  logic        cmd_rd,
    input  logic [15:0] cmd_data,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        init_done,
    output logic        lcd2_cs_hw,
    output logic        lcd2_wr_hw,
    output logic        lcd2_rs_hw,
    output logic        lcd2_reset_hw,
    output logic        lcd2_rd_hw,
    output logic [15:0] lcd2_data16_hw,
    output logic        lcd2_data16_oe,
    input  logic [15:0] lcd2_data16_in
);

    typedef enum logic [2:0] {
        RST_LOW  = 3'd0,
        RST_WAIT = 3'd1,
        IDLE     = 3'd2,
        WR_LO    = 3'd3,
        WR_HI    = 3'd4,
        RD_LO    = 3'd5,
        RD_HI    = 3'd6
    } state_t;

    state_t      state;
    logic [23:0] cnt;
    logic        accept;

    assign accept = cmd_valid && cmd_ready;

`ifndef LCD_READ_EN
    // Without the read path the bus is always driven and never strobed for reads.
    logic unused_read_inputs;
    assign unused_read_inputs = ^{cmd_rd, lcd2_data16_in};
    assign lcd2_rd_hw     = 1'b1;
    assign lcd2_data16_oe = 1'b1;
    assign rd_valid       = 1'b0;
    assign rd_data        = 16'h0000;
`endif

    // Bus sequencer: one down-counter times every state; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RST_LOW;
            cnt            <= 24'(RST_LOW_CYC - 1);
            cmd_ready      <= 1'b0;
            init_done      <= 1'b0;
            lcd2_cs_hw     <= 1'b1;
            lcd2_wr_hw     <= 1'b1;
            lcd2_rs_hw     <= 1'b0;
            lcd2_reset_hw  <= 1'b0;
            lcd2_data16_hw <= 16'h0000;
`ifdef LCD_READ_EN
            lcd2_rd_hw     <= 1'b1;
            lcd2_data16_oe <= 1'b1;
            rd_valid       <= 1'b0;
            rd_data        <= 16'h0000;
`endif
        end else begin
`ifdef LCD_READ_EN
            rd_valid <= 1'b0;
`endif
            if (accept) begin
                // New transfer: CS stays or goes low with no idle gap.
                lcd2_cs_hw     <= 1'b0;
                lcd2_rs_hw     <= cmd_rs;
                lcd2_data16_hw <= cmd_data;
                cmd_ready      <= 1'b0;
`ifdef LCD_READ_EN
                if (cmd_rd) begin
                    state          <= RD_LO;
                    cnt            <= 24'(RD_LOW_CYC - 1);
                    lcd2_rd_hw     <= 1'b0;
                    lcd2_wr_hw     <= 1'b1;
                    lcd2_data16_oe <= 1'b0;
                end else
`endif
                begin
                    state      <= WR_LO;
                    cnt        <= 24'(WR_LOW_CYC - 1);
                    lcd2_wr_hw <= 1'b0;
`ifdef LCD_READ_EN
                    lcd2_rd_hw     <= 1'b1;
                    lcd2_data16_oe <= 1'b1;
`endif
                end
            end else begin
                case (state)
                    RST_LOW: begin
                        if (cnt == 24'd0) begin
                            state         <= RST_WAIT;
                            cnt           <= 24'(RST_WAIT_CYC - 1);
                            lcd2_reset_hw <= 1'b1;
                        end else begin
                            cnt <= cnt - 24'd1;
                        end
                    end
                    RST_WAIT: begin
                        if (cnt == 24'd0) begin
                            state     <= IDLE;
                            init_done <= 1'b1;
                            cmd_ready <= 1'b1;
                        end else begin
                            cnt <= cnt - 24'd1;
                        end
                    end
                    IDLE: begin
                        lcd2_cs_hw <= 1'b1;
                        cmd_ready  <= 1'b1;
                    end
                    WR_LO: begin
                        if (cnt == 24'd0) begin
                            state      <= WR_HI;
                            cnt        <= 24'(WR_HIGH_CYC - 1);
                            lcd2_wr_hw <= 1'b1;
                            cmd_ready  <= (WR_HIGH_CYC == 1);
                        end else begin
                            cnt <= cnt - 24'd1;
                        end
                    end
                    WR_HI: begin
                        if (cnt == 24'd0) begin
                            state      <= IDLE;
                            lcd2_cs_hw <= 1'b1;
                        end else begin
                            cnt <= cnt - 24'd1;
                            if (cnt == 24'd1) cmd_ready <= 1'b1;
                        end
                    end
`ifdef LCD_READ_EN
                    RD_LO: begin
                        if (cnt == 24'd0) begin
                            state      <= RD_HI;
                            cnt        <= 24'(RD_HIGH_CYC - 1);
                            lcd2_rd_hw <= 1'b1;
                            rd_valid   <= 1'b1;
                            rd_data    <= lcd2_data16_in;
                            cmd_ready  <= (RD_HIGH_CYC == 1);
                        end else begin
                            cnt <= cnt - 24'd1;
                        end
                    end
                    RD_HI: begin
                        if (cnt == 24'd0) begin
                            state          <= IDLE;
                            lcd2_cs_hw     <= 1'b1;
                            lcd2_data16_oe <= 1'b1;
                        end else begin
                            cnt <= cnt - 24'd1;
                            if (cnt == 24'd1) cmd_ready <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state <= RST_LOW;
                        cnt   <= 24'(RST_LOW_CYC - 1);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_master.sv
// Testbench for lcd_bus_master: panel reset sequence, single and burst writes,
// reads (or ignored cmd_rd), random traffic and reset during a write.
module tb_lcd_bus_master;

    localparam int WL   = 2;
    localparam int WH   = 2;
    localparam int RL   = 4;
    localparam int RH   = 4;
    localparam int RSTL = 8;
    localparam int RSTW = 16;
`ifdef LCD_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    // clock / reset / DUT
    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rs;
    logic        cmd_rd;
    logic [15:0] cmd_data;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        init_done;
    logic        lcd2_cs_hw;
    logic        lcd2_wr_hw;
    logic        lcd2_rs_hw;
    logic        lcd2_reset_hw;
    logic        lcd2_rd_hw;
    logic [15:0] lcd2_data16_hw;
    logic        lcd2_data16_oe;
    logic [15:0] lcd2_data16_in;

    int n_checks = 0;
    int n_fail   = 0;

    // transfer table used by test_traffic
    logic        tx_rs   [64];
    logic        tx_rd   [64];
    logic [15:0] tx_data [64];
    logic [15:0] tx_in   [64];
    int          tx_gap  [64];

    lcd_bus_master #(
        .WR_LOW_CYC  (WL),
        .WR_HIGH_CYC (WH),
        .RD_LOW_CYC  (RL),
        .RD_HIGH_CYC (RH),
        .RST_LOW_CYC (RSTL),
        .RST_WAIT_CYC(RSTW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rs        (cmd_rs),
        .cmd_rd        (cmd_rd),
        .cmd_data      (cmd_data),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .init_done     (init_done),
        .lcd2_cs_hw    (lcd2_cs_hw),
        .lcd2_wr_hw    (lcd2_wr_hw),
        .lcd2_rs_hw    (lcd2_rs_hw),
        .lcd2_reset_hw (lcd2_reset_hw),
        .lcd2_rd_hw    (lcd2_rd_hw),
        .lcd2_data16_hw(lcd2_data16_hw),
        .lcd2_data16_oe(lcd2_data16_oe),
        .lcd2_data16_in(lcd2_data16_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_tx(input int i, input logic rs, input logic rd,
                          input logic [15:0] d, input logic [15:0] din, input int gap);
        tx_rs[i]   = rs;
        tx_rd[i]   = rd;
        tx_data[i] = d;
        tx_in[i]   = din;
        tx_gap[i]  = gap;
    endtask

    // Reset sequence; with mid_op a write is started and rst lands in WR_LO.
    task automatic test_reset(input bit mid_op);
        string nm;
        nm = mid_op ? "midop_reset" : "power_reset";
        if (mid_op) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_rd = 1'b0; cmd_data = 16'hA5A5;
            @(negedge clk);
            cmd_valid = 1'b0;
            n_checks++;
            if (lcd2_cs_hw !== 1'b0 || lcd2_wr_hw !== 1'b0) begin
                n_fail++;
                $display("FAIL %s in_wr_lo: cs=%b wr=%b required 0/0", nm, lcd2_cs_hw, lcd2_wr_hw);
            end
        end else begin
            @(negedge clk);
        end
        rst = 1'b1;
        cmd_valid = 1'b1;
        repeat (mid_op ? 1 : 2) @(negedge clk);
        n_checks++;
        if ({lcd2_cs_hw, lcd2_wr_hw, lcd2_rd_hw, lcd2_rs_hw, lcd2_reset_hw, lcd2_data16_oe}
            !== 6'b111001) begin
            n_fail++;
            $display("FAIL %s strobes: cs,wr,rd,rs,reset,oe=%b required 111001", nm,
                     {lcd2_cs_hw, lcd2_wr_hw, lcd2_rd_hw, lcd2_rs_hw, lcd2_reset_hw, lcd2_data16_oe});
        end
        n_checks++;
        if ({cmd_ready, rd_valid, init_done} !== 3'b000 || lcd2_data16_hw !== 16'h0000
            || rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s status: ready,rdv,init=%b data=%h rd_data=%h required 000/0000/0000",
                     nm, {cmd_ready, rd_valid, init_done}, lcd2_data16_hw, rd_data);
        end
        rst = 1'b0;
        for (int k = 1; k <= RSTL + RSTW + 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (lcd2_reset_hw !== (k >= RSTL)) begin
                n_fail++;
                $display("FAIL %s reset_hw clk %0d: got %b required %b", nm, k, lcd2_reset_hw, (k >= RSTL));
            end
            n_checks++;
            if (init_done !== (k >= RSTL + RSTW) || cmd_ready !== (k >= RSTL + RSTW)) begin
                n_fail++;
                $display("FAIL %s init clk %0d: init_done=%b cmd_ready=%b required %b", nm, k,
                         init_done, cmd_ready, (k >= RSTL + RSTW));
            end
            n_checks++;
            if (lcd2_cs_hw !== 1'b1 || lcd2_wr_hw !== 1'b1) begin
                n_fail++;
                $display("FAIL %s idle_bus clk %0d: cs=%b wr=%b required 1/1", nm, k, lcd2_cs_hw, lcd2_wr_hw);
            end
            cmd_valid = (k < RSTL + RSTW - 1);
        end
    endtask

    // Runs tx[0..n-1] through the DUT and checks every bus output each clock
    // against a timeline model: each transfer owns len clocks starting at its
    // accept edge, with the strobe low for the first phase.
    task automatic test_traffic(input string nm, input int n);
        bit          act = 1'b0;
        int          t = 0, len = 0, nxt = 0, gap_left, cyc = 0;
        bit          acc = 1'b0, ok;
        logic        c_rs = 1'b0, c_rd = 1'b0;
        logic [15:0] c_w = 16'h0, c_in = 16'h0;
        logic        e_cs, e_wr, e_rd, e_oe, e_rdy, e_rdv;
        gap_left = tx_gap[0];
        cmd_valid = 1'b0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            e_cs  = act ? 1'b0 : 1'b1;
            e_wr  = (act && !c_rd && t < WL) ? 1'b0 : 1'b1;
            e_rd  = (act && c_rd && t < RL) ? 1'b0 : 1'b1;
            e_oe  = (act && c_rd) ? 1'b0 : 1'b1;
            e_rdy = !act || (t == len - 1);
            e_rdv = act && c_rd && (t == RL);
            n_checks++;
            if ({lcd2_cs_hw, lcd2_wr_hw, lcd2_rd_hw, lcd2_data16_oe} !== {e_cs, e_wr, e_rd, e_oe}) begin
                n_fail++;
                $display("FAIL %s strobes cyc %0d: cs,wr,rd,oe=%b required %b", nm, cyc,
                         {lcd2_cs_hw, lcd2_wr_hw, lcd2_rd_hw, lcd2_data16_oe}, {e_cs, e_wr, e_rd, e_oe});
            end
            n_checks++;
            if (cmd_ready !== e_rdy || rd_valid !== e_rdv) begin
                n_fail++;
                $display("FAIL %s handshake cyc %0d: ready=%b rd_valid=%b required %b/%b", nm, cyc,
                         cmd_ready, rd_valid, e_rdy, e_rdv);
            end
            n_checks++;
            if (lcd2_reset_hw !== 1'b1 || init_done !== 1'b1) begin
                n_fail++;
                $display("FAIL %s init cyc %0d: reset_hw=%b init_done=%b required 1/1", nm, cyc,
                         lcd2_reset_hw, init_done);
            end
            if (act) begin
                n_checks++;
                if (lcd2_rs_hw !== c_rs || (!c_rd && lcd2_data16_hw !== c_w)) begin
                    n_fail++;
                    $display("FAIL %s word cyc %0d: rs=%b data=%h required rs=%b data=%h", nm, cyc,
                             lcd2_rs_hw, lcd2_data16_hw, c_rs, c_w);
                end
            end
            if (e_rdv || !READ_EN) begin
                n_checks++;
                if (rd_data !== (READ_EN ? c_in : 16'h0000)) begin
                    n_fail++;
                    $display("FAIL %s rd_data cyc %0d: got %h required %h", nm, cyc, rd_data,
                             (READ_EN ? c_in : 16'h0000));
                end
            end
            if (acc) begin
                cmd_valid = 1'b0;
                acc = 1'b0;
            end
            if (nxt >= n && !act) break;
            if (!cmd_valid && nxt < n) begin
                if (gap_left == 0) begin
                    cmd_valid = 1'b1;
                    cmd_rs    = tx_rs[nxt];
                    cmd_rd    = tx_rd[nxt];
                    cmd_data  = tx_data[nxt];
                end else begin
                    gap_left--;
                end
            end
            if (cmd_valid && e_rdy) begin
                acc  = 1'b1;
                act  = 1'b1;
                t    = 0;
                c_rs = tx_rs[nxt];
                c_rd = tx_rd[nxt] && READ_EN;
                c_w  = tx_data[nxt];
                c_in = tx_in[nxt];
                lcd2_data16_in = tx_in[nxt];
                len  = c_rd ? (RL + RH) : (WL + WH);
                nxt++;
                gap_left = (nxt < n) ? tx_gap[nxt] : 0;
            end else if (act) begin
                t++;
                if (t == len) act = 1'b0;
            end
        end
        ok = (nxt >= n) && !act;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s completion: %0d of %0d transfers done within cycle budget", nm, nxt, n);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_single_write();
        set_tx(0, 1'b0, 1'b0, 16'h002C, 16'h0000, 0);
        test_traffic("single_write", 1);
    endtask

    task automatic test_back_to_back();
        set_tx(0, 1'b1, 1'b0, 16'hF800, 16'h0000, 0);
        set_tx(1, 1'b1, 1'b0, 16'h07E0, 16'h0000, 0);
        set_tx(2, 1'b1, 1'b0, 16'h001F, 16'h0000, 0);
        set_tx(3, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 0);
        test_traffic("back_to_back", 4);
    endtask

    task automatic test_read();
        set_tx(0, 1'b1, 1'b1, 16'h1234, 16'h9341, 0);
        set_tx(1, 1'b0, 1'b1, 16'h00D3, 16'h5AC3, 0);
        set_tx(2, 1'b1, 1'b0, 16'h4321, 16'h0000, 0);
        test_traffic("read", 3);
    endtask

    task automatic test_random(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            set_tx(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                   int'($urandom_range(0, 3)));
        end
        test_traffic(nm, n);
    endtask

    initial begin
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_rs         = 1'b0;
        cmd_rd         = 1'b0;
        cmd_data       = 16'h0000;
        lcd2_data16_in = 16'h0000;
        test_reset(1'b0);
        test_single_write();
        test_back_to_back();
        test_read();
        test_random("random", 40);
        test_reset(1'b1);
        test_random("after_reset", 12);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
